// File: rtl/pipe_control.sv
// pipe_control: control path for a 5-stage in-order pipeline.
// Decodes the ID-stage instruction and carries its controls through the
// ID/EX, EX/MEM and MEM/WB registers. Handles external stalls, flushes and
// the end-of-program drain/halt sequence.
//
// Optional feature: define LOAD_USE_HAZARD_EN to enable internal load-use
// hazard detection (one bubble per load followed by a dependent instruction).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_valid/op/func/rs/rt/rd       ID-stage instruction
//   stall_in, flush_in              external stall request, redirect squash
//   stall_out                       ID/IF must hold this cycle
//   ex_*                            EX-stage controls and source registers
//   mem_valid/write/read_width,
//   mem_to_reg                      MEM-stage controls
//   wb_valid/reg_write/mem_to_reg,
//   wb_dest                         WB-stage controls
//   halted                          EOP reached and pipeline drained
//
// FSM states:
//   state    | meaning
//   S_RUN    | normal issue
//   S_DRAIN  | EOP accepted; bubbles issued while older work retires
//   S_HALTED | pipeline empty; held until reset
module pipe_control #(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 4,
  parameter int MEMW_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_func,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_alu_shift_imm,
  output logic              ex_zero_ex,
  output logic              ex_load_imm,
  output logic              ex_branch,
  output logic              ex_branch_type,
  output logic              ex_jump,
  output logic [ALUC_W-1:0] ex_alu_ctrl,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic              mem_valid,
  output logic [MEMW_W-1:0] mem_write,
  output logic [1:0]        mem_read_width,
  output logic              mem_to_reg,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dest,
  output logic              halted
);

  typedef struct packed {
    logic              valid;
    logic              reg_dst;
    logic              alu_src;
    logic              shift_imm;
    logic              zero_ex;
    logic              load_imm;
    logic              branch;
    logic              branch_type;
    logic              jump;
    logic              mem_to_reg;
    logic              reg_write;
    logic [ALUC_W-1:0] alu_ctrl;
    logic [MEMW_W-1:0] mem_write;
    logic [1:0]        rd_width;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dest;
  } idex_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t state_q;
  logic [1:0] cnt_q;
  logic halted_q;

  idex_t dec, idex_d, idex_q;
  logic dec_eop, hazard, take;

  logic              exmem_valid_q, exmem_m2r_q, exmem_rw_q;
  logic [MEMW_W-1:0] exmem_mw_q;
  logic [1:0]        exmem_width_q;
  logic [REG_AW-1:0] exmem_dest_q;
  logic              memwb_valid_q, memwb_rw_q, memwb_m2r_q;
  logic [REG_AW-1:0] memwb_dest_q;

  always_comb begin
    dec = '0;
    dec_eop = 1'b0;
    dec.valid = 1'b1;
    dec.rs = id_rs;
    dec.rt = id_rt;
    unique case (id_op)
      6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011, 6'b100111: begin
        dec.alu_ctrl   = ALUC_W'(3);
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        // op[1:0]: 00 byte, 01 half, 11 word
        dec.rd_width   = (id_op[1:0] == 2'b00) ? 2'd2 :
                         (id_op[1:0] == 2'b01) ? 2'd1 : 2'd0;
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.alu_ctrl  = ALUC_W'(3);
        dec.alu_src   = 1'b1;
        dec.mem_write = (id_op[1:0] == 2'b00) ? MEMW_W'(4'b0001) :
                        (id_op[1:0] == 2'b01) ? MEMW_W'(4'b0011) : MEMW_W'(4'b1111);
      end
      6'b001000: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(3); end
      6'b001100: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(5); dec.zero_ex = 1'b1; end
      6'b001101: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(6); dec.zero_ex = 1'b1; end
      6'b001110: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(7); dec.zero_ex = 1'b1; end
      6'b001010: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(9); end
      6'b001111: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_ctrl = ALUC_W'(0); dec.load_imm = 1'b1; end
      6'b000100: begin dec.alu_ctrl = ALUC_W'(4); dec.branch = 1'b1; end
      6'b000101: begin dec.alu_ctrl = ALUC_W'(4); dec.branch = 1'b1; dec.branch_type = 1'b1; end
      6'b000010: begin dec.alu_ctrl = ALUC_W'(4); dec.jump = 1'b1; end
      6'b111111: dec_eop = 1'b1;
      default: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.shift_imm = (id_func == 6'd0) || (id_func == 6'd2) || (id_func == 6'd3);
        unique case (id_func)
          6'b000000, 6'b000100: dec.alu_ctrl = ALUC_W'(0);
          6'b000010, 6'b000110: dec.alu_ctrl = ALUC_W'(1);
          6'b000011, 6'b000111: dec.alu_ctrl = ALUC_W'(2);
          6'b100000: dec.alu_ctrl = ALUC_W'(3);
          6'b100010: dec.alu_ctrl = ALUC_W'(4);
          6'b100100: dec.alu_ctrl = ALUC_W'(5);
          6'b100101: dec.alu_ctrl = ALUC_W'(6);
          6'b100110: dec.alu_ctrl = ALUC_W'(7);
          6'b100111: dec.alu_ctrl = ALUC_W'(8);
          6'b101010: dec.alu_ctrl = ALUC_W'(9);
          default: begin dec.alu_ctrl = '1; dec.reg_write = 1'b0; end
        endcase
      end
    endcase
    dec.dest = dec.reg_dst ? id_rd : id_rt;
  end

`ifdef LOAD_USE_HAZARD_EN
  assign hazard = idex_q.valid && idex_q.mem_to_reg && (idex_q.dest != '0) &&
                  ((idex_q.dest == id_rs) || (idex_q.dest == id_rt)) && id_valid;
`else
  assign hazard = 1'b0;
`endif

  // A flush squashes the ID instruction anyway, so it overrides any stall.
  assign stall_out = !flush_in && (stall_in || hazard || (state_q != S_RUN));
  assign take      = id_valid && !flush_in && !stall_out && (state_q == S_RUN);
  assign idex_d    = take ? dec : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q        <= '0;
      exmem_valid_q <= 1'b0;
      exmem_m2r_q   <= 1'b0;
      exmem_rw_q    <= 1'b0;
      exmem_mw_q    <= '0;
      exmem_width_q <= '0;
      exmem_dest_q  <= '0;
      memwb_valid_q <= 1'b0;
      memwb_rw_q    <= 1'b0;
      memwb_m2r_q   <= 1'b0;
      memwb_dest_q  <= '0;
    end else begin
      idex_q        <= idex_d;
      exmem_valid_q <= idex_q.valid;
      exmem_m2r_q   <= idex_q.mem_to_reg;
      exmem_rw_q    <= idex_q.reg_write;
      exmem_mw_q    <= idex_q.mem_write;
      exmem_width_q <= idex_q.rd_width;
      exmem_dest_q  <= idex_q.dest;
      memwb_valid_q <= exmem_valid_q;
      memwb_rw_q    <= exmem_rw_q;
      memwb_m2r_q   <= exmem_m2r_q;
      memwb_dest_q  <= exmem_dest_q;
    end
  end

  // Drain counts 3 -> 0; the move to HALTED coincides with the EOP leaving WB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_RUN: if (take && dec_eop) begin
          state_q <= S_DRAIN;
          cnt_q   <= 2'd3;
        end
        S_DRAIN: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: halted_q <= 1'b1;
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign ex_valid         = idex_q.valid;
  assign ex_reg_dst       = idex_q.reg_dst;
  assign ex_alu_src       = idex_q.alu_src;
  assign ex_alu_shift_imm = idex_q.shift_imm;
  assign ex_zero_ex       = idex_q.zero_ex;
  assign ex_load_imm      = idex_q.load_imm;
  assign ex_branch        = idex_q.branch;
  assign ex_branch_type   = idex_q.branch_type;
  assign ex_jump          = idex_q.jump;
  assign ex_alu_ctrl      = idex_q.alu_ctrl;
  assign ex_rs            = idex_q.rs;
  assign ex_rt            = idex_q.rt;
  assign mem_valid        = exmem_valid_q;
  assign mem_write        = exmem_mw_q;
  assign mem_read_width   = exmem_width_q;
  assign mem_to_reg       = exmem_m2r_q;
  assign wb_valid         = memwb_valid_q;
  assign wb_reg_write     = memwb_rw_q;
  assign wb_mem_to_reg    = memwb_m2r_q;
  assign wb_dest          = memwb_dest_q;
  assign halted           = halted_q;

endmodule
